// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, instruction field
// positions and execute-stage FSM state encodings.
package cpu_pkg;

   localparam int OP_HI  = 31;
   localparam int OP_LO  = 26;
   localparam int RS_HI  = 25;
   localparam int RS_LO  = 21;
   localparam int RT_HI  = 20;
   localparam int RT_LO  = 16;
   localparam int RD_HI  = 15;
   localparam int RD_LO  = 11;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;

   typedef logic [5:0] opcode_t;

   localparam opcode_t OP_NOP   = 6'b000000;
   localparam opcode_t OP_ADD   = 6'b000001;
   localparam opcode_t OP_SUB   = 6'b000010;
   localparam opcode_t OP_AND   = 6'b000011;
   localparam opcode_t OP_OR    = 6'b000100;
   localparam opcode_t OP_XOR   = 6'b000101;
   localparam opcode_t OP_ADDI  = 6'b000110;
   localparam opcode_t OP_SUBI  = 6'b000111;
   localparam opcode_t OP_ANDI  = 6'b001000;
   localparam opcode_t OP_ORI   = 6'b001001;
   localparam opcode_t OP_LOAD  = 6'b001010;
   localparam opcode_t OP_STORE = 6'b001011;
   localparam opcode_t OP_SHR   = 6'b010001;
   localparam opcode_t OP_SHL   = 6'b010010;
   localparam opcode_t OP_BR    = 6'b100000;
   localparam opcode_t OP_JMP   = 6'b100001;
   localparam opcode_t OP_BEQ   = 6'b100010;
   localparam opcode_t OP_BLT   = 6'b100011;
   localparam opcode_t OP_BGT   = 6'b100100;
   localparam opcode_t OP_HALT  = 6'b111111;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } ex_state_e;

   function automatic logic is_branch(input opcode_t op);
      return (op == OP_BR) || (op == OP_BEQ) ||
             (op == OP_BLT) || (op == OP_BGT);
   endfunction

   function automatic logic is_shift(input opcode_t op);
      return (op == OP_SHR) || (op == OP_SHL);
   endfunction

endpackage

// File: rtl/ex_serial_shifter.sv
// Bit-serial logical shifter: one position per clk1 edge,
// done asserted during the final shifting cycle.
module ex_serial_shifter #(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = 5
) (
   input  logic              clk1,
   input  logic              reset,
   input  logic              start,
   input  logic              left,
   input  logic [DATA_W-1:0] a,
   input  logic [SHAMT_W-1:0] n,
   output logic              done,
   output logic [DATA_W-1:0] result
);

   localparam logic [SHAMT_W-1:0] ONE = SHAMT_W'(1);

   logic [DATA_W-1:0]  acc;
   logic [DATA_W-1:0]  acc_next;
   logic [SHAMT_W-1:0] cnt;
   logic               dir_left;

   assign acc_next = dir_left ? (acc << 1) : (acc >> 1);
   assign done     = (cnt == ONE);
   assign result   = acc_next;

   always_ff @(posedge clk1) begin
      if (reset) begin
         acc      <= '0;
         cnt      <= '0;
         dir_left <= 1'b0;
      end else if (start) begin
         acc      <= a;
         cnt      <= n;
         dir_left <= left;
      end else if (cnt != '0) begin
         acc <= acc_next;
         cnt <= cnt - ONE;
      end
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, address generation, branch resolution
// and a serial shifter that back-pressures decode.
module ex_stage
   import cpu_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = 5
) (
   input  logic              clk1,
   input  logic              reset,
   input  logic              id_ex_valid,
   output logic              id_ex_ready,
   input  logic [31:0]       id_ex_ir,
   input  logic [DATA_W-1:0] id_ex_a,
   input  logic [DATA_W-1:0] id_ex_b,
   input  logic [DATA_W-1:0] id_ex_imm,
   input  logic [31:0]       id_ex_npc,
   output logic              ex_mem_valid,
   output logic [31:0]       ex_mem_ir,
   output logic [DATA_W-1:0] ex_mem_aluout,
   output logic [DATA_W-1:0] ex_mem_b,
   output logic              ex_mem_cond,
   output logic              branch_taken,
   output logic [31:0]       branch_target,
   output logic              halted
);

   ex_state_e state;
   ex_state_e state_next;

   opcode_t            op;
   logic               accept;
   logic [SHAMT_W-1:0] shamt;
   logic [31:0]        imm32;
   logic [31:0]        target;

   logic [DATA_W-1:0]  alu_res;
   logic               cond_res;
   logic               br_op;
   logic               sh_start;

   logic               sh_done;
   logic [DATA_W-1:0]  sh_result;

   logic [31:0]        pend_ir;
   logic [DATA_W-1:0]  pend_b;

   assign op          = id_ex_ir[OP_HI:OP_LO];
   assign shamt       = id_ex_imm[SHAMT_W-1:0];
   assign imm32       = 32'($signed(id_ex_imm));
   assign target      = id_ex_npc + imm32;
   assign id_ex_ready = (state == S_IDLE) && !halted;
   assign accept      = id_ex_valid && id_ex_ready;

   always_comb begin
      alu_res  = '0;
      cond_res = 1'b0;
      br_op    = is_branch(op);
      sh_start = accept && is_shift(op) && (shamt != '0);
      unique case (op)
         OP_ADD:   alu_res = id_ex_a + id_ex_b;
         OP_SUB:   alu_res = id_ex_a - id_ex_b;
         OP_AND:   alu_res = id_ex_a & id_ex_b;
         OP_OR:    alu_res = id_ex_a | id_ex_b;
         OP_XOR:   alu_res = id_ex_a ^ id_ex_b;
         OP_ADDI:  alu_res = id_ex_a + id_ex_imm;
         OP_SUBI:  alu_res = id_ex_a - id_ex_imm;
         OP_ANDI:  alu_res = id_ex_a & id_ex_imm;
         OP_ORI:   alu_res = id_ex_a | id_ex_imm;
         OP_LOAD:  alu_res = id_ex_a + id_ex_imm;
         OP_STORE: alu_res = id_ex_a + id_ex_imm;
         // zero-length shifts bypass the serial unit
         OP_SHR:   alu_res = id_ex_a;
         OP_SHL:   alu_res = id_ex_a;
         OP_BR: begin
            alu_res  = DATA_W'(target);
            cond_res = 1'b1;
         end
         OP_BEQ: begin
            alu_res  = DATA_W'(target);
            cond_res = (id_ex_a == id_ex_b);
         end
         OP_BLT: begin
            alu_res  = DATA_W'(target);
            cond_res = $signed(id_ex_a) < $signed(id_ex_b);
         end
         OP_BGT: begin
            alu_res  = DATA_W'(target);
            cond_res = $signed(id_ex_a) > $signed(id_ex_b);
         end
         default: begin
            alu_res  = '0;
            cond_res = 1'b0;
         end
      endcase
   end

   ex_serial_shifter #(
      .DATA_W  (DATA_W),
      .SHAMT_W (SHAMT_W)
   ) u_shifter (
      .clk1   (clk1),
      .reset  (reset),
      .start  (sh_start),
      .left   (op == OP_SHL),
      .a      (id_ex_a),
      .n      (shamt),
      .done   (sh_done),
      .result (sh_result)
   );

   always_ff @(posedge clk1) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE:  if (sh_start) state_next = S_SHIFT;
         S_SHIFT: if (sh_done)  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk1) begin
      if (reset) begin
         ex_mem_valid  <= 1'b0;
         ex_mem_ir     <= '0;
         ex_mem_aluout <= '0;
         ex_mem_b      <= '0;
         ex_mem_cond   <= 1'b0;
         branch_taken  <= 1'b0;
         branch_target <= '0;
         halted        <= 1'b0;
         pend_ir       <= '0;
         pend_b        <= '0;
      end else begin
         ex_mem_valid <= 1'b0;
         branch_taken <= 1'b0;
         if (state == S_SHIFT && sh_done) begin
            ex_mem_valid  <= 1'b1;
            ex_mem_ir     <= pend_ir;
            ex_mem_aluout <= sh_result;
            ex_mem_b      <= pend_b;
            ex_mem_cond   <= 1'b0;
         end else if (accept) begin
            if (sh_start) begin
               pend_ir <= id_ex_ir;
               pend_b  <= id_ex_b;
            end else begin
               ex_mem_valid  <= 1'b1;
               ex_mem_ir     <= id_ex_ir;
               ex_mem_aluout <= alu_res;
               ex_mem_b      <= id_ex_b;
               ex_mem_cond   <= cond_res;
               branch_taken  <= br_op && cond_res;
               if (br_op) branch_target <= target;
               if (op == OP_HALT) halted <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expected EX/MEM records are
// queued at accept and compared when ex_mem_valid pulses.
module tb_ex_stage;

   localparam logic [5:0] OP_NOP   = 6'b000000;
   localparam logic [5:0] OP_ADD   = 6'b000001;
   localparam logic [5:0] OP_SUB   = 6'b000010;
   localparam logic [5:0] OP_AND   = 6'b000011;
   localparam logic [5:0] OP_OR    = 6'b000100;
   localparam logic [5:0] OP_XOR   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b000110;
   localparam logic [5:0] OP_SUBI  = 6'b000111;
   localparam logic [5:0] OP_ANDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001001;
   localparam logic [5:0] OP_LOAD  = 6'b001010;
   localparam logic [5:0] OP_STORE = 6'b001011;
   localparam logic [5:0] OP_SHR   = 6'b010001;
   localparam logic [5:0] OP_SHL   = 6'b010010;
   localparam logic [5:0] OP_BR    = 6'b100000;
   localparam logic [5:0] OP_JMP   = 6'b100001;
   localparam logic [5:0] OP_BEQ   = 6'b100010;
   localparam logic [5:0] OP_BLT   = 6'b100011;
   localparam logic [5:0] OP_BGT   = 6'b100100;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   typedef struct {
      logic [31:0] ir;
      logic [31:0] alu;
      logic [31:0] b;
      logic [31:0] tgt;
      logic        cond;
      logic        tk;
      int          edge_no;
   } exp_t;

   logic        clk1 = 1'b0;
   logic        reset = 1'b1;
   logic        id_ex_valid = 1'b0;
   logic        id_ex_ready;
   logic [31:0] id_ex_ir = '0;
   logic [31:0] id_ex_a = '0;
   logic [31:0] id_ex_b = '0;
   logic [31:0] id_ex_imm = '0;
   logic [31:0] id_ex_npc = '0;
   logic        ex_mem_valid;
   logic [31:0] ex_mem_ir;
   logic [31:0] ex_mem_aluout;
   logic [31:0] ex_mem_b;
   logic        ex_mem_cond;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        halted;

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   exp_t q[$];

   always #5 clk1 = ~clk1;

   ex_stage dut (
      .clk1          (clk1),
      .reset         (reset),
      .id_ex_valid   (id_ex_valid),
      .id_ex_ready   (id_ex_ready),
      .id_ex_ir      (id_ex_ir),
      .id_ex_a       (id_ex_a),
      .id_ex_b       (id_ex_b),
      .id_ex_imm     (id_ex_imm),
      .id_ex_npc     (id_ex_npc),
      .ex_mem_valid  (ex_mem_valid),
      .ex_mem_ir     (ex_mem_ir),
      .ex_mem_aluout (ex_mem_aluout),
      .ex_mem_b      (ex_mem_b),
      .ex_mem_cond   (ex_mem_cond),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .halted        (halted)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [5:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  input logic [31:0] imm,
                                  input logic [31:0] npc,
                                  input int now);
      exp_t e;
      int   n;
      n         = int'(imm[4:0]);
      e.ir      = {op, 10'h0, imm[15:0]};
      e.b       = b;
      e.alu     = 32'h0;
      e.cond    = 1'b0;
      e.tk      = 1'b0;
      e.tgt     = npc + imm;
      e.edge_no = now + 1;
      case (op)
         OP_ADD:   e.alu = a + b;
         OP_SUB:   e.alu = a - b;
         OP_AND:   e.alu = a & b;
         OP_OR:    e.alu = a | b;
         OP_XOR:   e.alu = a ^ b;
         OP_ADDI:  e.alu = a + imm;
         OP_SUBI:  e.alu = a - imm;
         OP_ANDI:  e.alu = a & imm;
         OP_ORI:   e.alu = a | imm;
         OP_LOAD,
         OP_STORE: e.alu = a + imm;
         OP_SHR: begin
            e.alu     = a >> n;
            e.edge_no = now + 1 + n;
         end
         OP_SHL: begin
            e.alu     = a << n;
            e.edge_no = now + 1 + n;
         end
         OP_BR:  e.cond = 1'b1;
         OP_BEQ: e.cond = (a == b);
         OP_BLT: e.cond = $signed(a) < $signed(b);
         OP_BGT: e.cond = $signed(a) > $signed(b);
         default: ;
      endcase
      if (op == OP_BR || op == OP_BEQ ||
          op == OP_BLT || op == OP_BGT) begin
         e.alu = e.tgt;
         e.tk  = e.cond;
      end
      return e;
   endfunction

   task automatic send(input logic [5:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] imm,
                       input logic [31:0] npc);
      int w = 0;
      @(negedge clk1);
      id_ex_ir    = {op, 10'h0, imm[15:0]};
      id_ex_a     = a;
      id_ex_b     = b;
      id_ex_imm   = imm;
      id_ex_npc   = npc;
      id_ex_valid = 1'b1;
      while (!id_ex_ready && w < 100) begin
         @(negedge clk1);
         w++;
      end
      if (!id_ex_ready) begin
         check("ready_timeout", 32'(id_ex_ready), 32'h1);
      end else begin
         q.push_back(model(op, a, b, imm, npc, cyc));
         @(negedge clk1);
      end
      id_ex_valid = 1'b0;
   endtask

   always @(posedge clk1) begin
      exp_t e;
      #1;
      cyc = cyc + 1;
      if (branch_taken && !ex_mem_valid)
         check("taken_without_valid", 32'(branch_taken), 32'h0);
      if (ex_mem_valid) begin
         if (q.size() == 0) begin
            check("spurious_pulse", 32'(ex_mem_valid), 32'h0);
         end else begin
            e = q.pop_front();
            check("ir", ex_mem_ir, e.ir);
            check("aluout", ex_mem_aluout, e.alu);
            check("b", ex_mem_b, e.b);
            check("cond", 32'(ex_mem_cond), 32'(e.cond));
            check("taken", 32'(branch_taken), 32'(e.tk));
            check("latency_edge", 32'(cyc), 32'(e.edge_no));
            if (e.tk) check("target", branch_target, e.tgt);
         end
      end
   end

   task automatic check_cleared(input string tag);
      check({tag, "_valid"}, 32'(ex_mem_valid), 32'h0);
      check({tag, "_ir"}, ex_mem_ir, 32'h0);
      check({tag, "_alu"}, ex_mem_aluout, 32'h0);
      check({tag, "_b"}, ex_mem_b, 32'h0);
      check({tag, "_cond"}, 32'(ex_mem_cond), 32'h0);
      check({tag, "_taken"}, 32'(branch_taken), 32'h0);
      check({tag, "_target"}, branch_target, 32'h0);
      check({tag, "_halted"}, 32'(halted), 32'h0);
      check({tag, "_ready"}, 32'(id_ex_ready), 32'h1);
   endtask

   logic [5:0] rops [15] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                             OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI,
                             OP_LOAD, OP_STORE, OP_SHR, OP_SHL,
                             OP_BEQ, OP_BLT};

   initial begin
      int lowc;
      int w;
      logic [5:0]  op;
      logic [31:0] a, b, imm;
      logic [15:0] i16;

      repeat (3) @(negedge clk1);
      reset = 1'b0;
      check_cleared("reset");

      send(OP_ADD, 32'd5, 32'd7, 32'd0, 32'h0);
      send(OP_SUBI, 32'd3, 32'd0, 32'hFFFF_FFFB, 32'h0);
      send(OP_LOAD, 32'h10, 32'hDEAD_BEEF, 32'd4, 32'h0);
      send(OP_STORE, 32'h100, 32'h1234_5678, 32'hFFFF_FFF0, 32'h0);
      send(OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'd8, 32'h20);
      send(OP_BGT, 32'hFFFF_FFFF, 32'd1, 32'd8, 32'h20);
      send(OP_BEQ, 32'd9, 32'd9, 32'hFFFF_FFFC, 32'h40);
      send(OP_BR, 32'd0, 32'd0, 32'h10, 32'hFFFF_FFF8);
      send(OP_JMP, 32'd1, 32'd2, 32'h30, 32'h80);
      send(OP_NOP, 32'd1, 32'd2, 32'h3, 32'h0);
      send(6'b011111, 32'd4, 32'd5, 32'h6, 32'h0);

      send(OP_SHL, 32'h1, 32'hAA, 32'd4, 32'h0);
      lowc = 0;
      while (!id_ex_ready && lowc < 50) begin
         lowc++;
         @(negedge clk1);
      end
      check("shl_ready_low_cycles", 32'(lowc), 32'd4);

      send(OP_SHR, 32'h8000_0001, 32'h0, 32'd0, 32'h0);
      send(OP_SHR, 32'hF000_0000, 32'h5, 32'd3, 32'h0);
      send(OP_SHL, 32'h1, 32'h6, 32'd31, 32'h0);

      for (int k = 0; k < 24; k++) begin
         op  = rops[$urandom_range(0, 14)];
         a   = $urandom;
         b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
         i16 = 16'($urandom);
         if (op == OP_SHR || op == OP_SHL)
            i16 = 16'($urandom_range(0, 7));
         imm = {{16{i16[15]}}, i16};
         send(op, a, b, imm, $urandom);
      end

      w = 0;
      while (q.size() != 0 && w < 200) begin
         @(negedge clk1);
         w++;
      end
      check("drain_before_abort", 32'(q.size()), 32'h0);

      send(OP_SHL, 32'h1, 32'h77, 32'd10, 32'h0);
      repeat (2) @(negedge clk1);
      reset = 1'b1;
      q.delete();
      @(negedge clk1);
      reset = 1'b0;
      check_cleared("abort");
      repeat (15) @(negedge clk1);
      check("abort_ready_idle", 32'(id_ex_ready), 32'h1);

      send(OP_HALT, 32'd1, 32'd2, 32'h0, 32'h0);
      check("halted_set", 32'(halted), 32'h1);
      id_ex_ir    = {OP_ADD, 26'h0};
      id_ex_a     = 32'd1;
      id_ex_b     = 32'd1;
      id_ex_valid = 1'b1;
      repeat (8) @(negedge clk1);
      check("halt_ready_low", 32'(id_ex_ready), 32'h0);
      check("halt_sticky", 32'(halted), 32'h1);
      check("halt_ir_held", ex_mem_ir, {OP_HALT, 26'h0});
      id_ex_valid = 1'b0;

      reset = 1'b1;
      @(negedge clk1);
      reset = 1'b0;
      check_cleared("halt_reset");

      send(OP_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 32'h0);
      w = 0;
      while (q.size() != 0 && w < 200) begin
         @(negedge clk1);
         w++;
      end
      check("final_drain", 32'(q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage clk1/clk2 pipeline.
- Consumes the ID/EX latch (instruction, operands A/B, sign-extended immediate, NPC) and produces the EX/MEM latch consumed by the memory stage on clk2.
- Performs ALU ops, load/store address generation, condition evaluation and branch-target resolution.
- Shifts use a multi-cycle serial shifter; the stage stalls decode via a ready/valid handshake while a shift is in progress.

Parameters:
- DATA_W, 32: datapath width of operands, immediate and results.
- SHAMT_W, 5: width of the shift-amount field, taken from imm[SHAMT_W-1:0].

Ports:
- clk1  in  1  stage clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- id_ex_valid  in  1  ID/EX latch holds a valid instruction.
- id_ex_ready  out  1  stage can accept an instruction this edge.
- id_ex_ir  in  32  instruction; op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0].
- id_ex_a  in  DATA_W  rs operand.
- id_ex_b  in  DATA_W  rt operand.
- id_ex_imm  in  DATA_W  sign-extended immediate.
- id_ex_npc  in  32  PC value carried with the instruction.
- ex_mem_valid  out  1  one-cycle pulse; EX/MEM latch updated this edge.
- ex_mem_ir  out  32  instruction passed through.
- ex_mem_aluout  out  DATA_W  ALU result or memory address.
- ex_mem_b  out  DATA_W  store data (id_ex_b passed through).
- ex_mem_cond  out  1  branch condition result.
- branch_taken  out  1  one-cycle pulse; upstream redirects PC and flushes IF/ID.
- branch_target  out  32  redirect address; valid while branch_taken=1.
- halted  out  1  sticky; set by Halt, cleared only by reset.

Behaviour:
- Reset (synchronous, clk1): all outputs 0, FSM to IDLE, shift counter 0, halted=0. Reset during SHIFT aborts the shift with no output pulse.
- Accept: an instruction is accepted on a posedge where id_ex_valid && id_ex_ready.
- id_ex_ready = (state==IDLE) && !halted.
- Single-cycle ops: the EX/MEM registers load on the accept edge and ex_mem_valid=1 for that cycle only. Latency is 1 edge. Registers hold their values otherwise.
- Op encodings and results:
  - ADD 000001: A+B. SUB 000010: A-B. AND 000011: A&B. OR 000100: A|B. XOR 000101: A^B.
  - ADDI 000110: A+imm. SUBI 000111: A-imm. ANDI 001000: A&imm. ORI 001001: A|imm.
  - Load 001010 / Store 001011: aluout = A+imm (address); ex_mem_b = B.
  - All arithmetic is modulo 2^DATA_W; no overflow flag.
- Branches (target = id_ex_npc + imm, modulo 2^32):
  - branch 100000: unconditional, cond=1.
  - Beq 100010: cond = (A==B).
  - Blt 100011: cond = signed A<B.
  - Bgt 100100: cond = signed A>B.
  - branch_taken = cond, pulsed on the same edge as ex_mem_valid; aluout = target.
- Jmp 100001: resolved in decode. Treated here as a no-op: aluout=0, cond=0, no branch_taken.
- Nop 000000 and undefined opcodes: aluout=0, cond=0, no branch_taken. The pass-through ex_mem_valid pulse is still issued.
- Halt 111111: emits one ex_mem_valid pulse carrying the Halt IR and sets halted on the same edge. id_ex_ready is low thereafter; further inputs are ignored.
- Shifts (shiftR 010001 logical right, shiftL 010010 logical left), amount N = imm[4:0]:
  - N=0: single-cycle, aluout=A.
  - N>0: on accept, acc<=A, cnt<=N, state IDLE->SHIFT.
  - Each SHIFT edge: acc shifts by 1, cnt decrements.
  - On the edge where cnt==1: the final value is written to aluout, ex_mem_valid pulses, state->IDLE.
  - Result appears N edges after the accept edge; id_ex_ready is low for exactly N cycles.
  - IR and B are captured at accept and held for the output.
- FSM states: IDLE, SHIFT.
  - IDLE->SHIFT: shift accepted with N>0.
  - SHIFT->IDLE: cnt==1 edge, or reset.
  - halted is orthogonal to the FSM state.
- Simultaneous events: a branch that fires on the same edge as a newly accepted instruction has no effect on that instruction; upstream flush is decode's responsibility.

Decomposition:
- Shared package cpu_pkg holds: the opcode constants (listed above), instruction field bit positions, and the FSM state encodings.
- One natural sub-module: ex_serial_shifter, which contains acc, cnt and the done pulse.

Test Plan:
- ADD, A=5, B=7 -> next edge: aluout=12, ex_mem_valid pulse, branch_taken=0.
- SUBI, A=3, imm=-5 (0xFFFFFFFB) -> aluout=8. Load, A=0x10, imm=4 -> aluout=0x14, ex_mem_b=B.
- Blt, A=-1, B=1, npc=0x20, imm=8 -> cond=1, branch_taken pulse, branch_target=0x28. Bgt with the same operands -> cond=0, no pulse.
- shiftL, A=0x1, N=4 -> ready low 4 cycles, aluout=0x10 on the 4th edge after accept. shiftR N=0 -> 1-edge latency.
- Reset asserted mid-shift (N=10, after 3 edges) -> no output pulse, outputs 0, ready=1 on the next edge.
- Halt followed by ADD held valid -> one pulse with Halt IR, halted=1, ready stays 0, ADD never emitted; reset clears halted.
